// File: rtl/strobe_capture_bank.sv
// Multi-channel strobe-qualified capture bank: per-channel edge detect, data capture, valid/ack, sticky overrun.
// Optional macro STROBE_SYNC_EN adds a 2-flop strobe synchroniser with a matching 2-deep data pipeline.
module strobe_capture_bank #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int CW   = 4,
  parameter int EDGE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    strobe,
  input  logic [NCH*W-1:0]  data,
  input  logic [NCH-1:0]    ack,
  output logic [NCH*W-1:0]  q,
  output logic [NCH-1:0]    valid,
  output logic [NCH-1:0]    overrun,
  output logic [NCH*CW-1:0] count
);

  generate
    if (EDGE < 0 || EDGE > 2) begin : g_bad_edge
      $error("strobe_capture_bank: EDGE must be 0 (rise), 1 (fall) or 2 (both)");
    end
  endgenerate

  logic [NCH-1:0]   strobe_s;
  logic [NCH*W-1:0] data_s;
  logic [NCH-1:0]   prev;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;
  logic [NCH-1:0]   hit;

`ifdef STROBE_SYNC_EN
  logic [NCH-1:0]   strobe_p0;
  logic [NCH-1:0]   strobe_p1;
  logic [NCH*W-1:0] data_p0;
  logic [NCH*W-1:0] data_p1;

  // Synchroniser stages p0/p1; reset to the live strobe so no edge appears after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_p0 <= strobe;
      strobe_p1 <= strobe;
    end else begin
      strobe_p0 <= strobe;
      strobe_p1 <= strobe_p0;
    end
  end

  always_ff @(posedge clk) begin
    data_p0 <= data;
    data_p1 <= data_p0;
  end

  assign strobe_s = strobe_p1;
  assign data_s   = data_p1;
`else
  assign strobe_s = strobe;
  assign data_s   = data;
`endif

  assign rise = strobe_s & ~prev;
  assign fall = ~strobe_s & prev;

  generate
    if (EDGE == 0) begin : g_hit_rise
      assign hit = rise;
    end else if (EDGE == 1) begin : g_hit_fall
      assign hit = fall;
    end else begin : g_hit_both
      assign hit = rise | fall;
    end
  endgenerate

  // Capture stage: an ack coinciding with a hit counts as consuming the old word
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= strobe;
      q       <= '0;
      valid   <= '0;
      overrun <= '0;
      count   <= '0;
    end else begin
      prev <= strobe_s;
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          q[i*W +: W]     <= data_s[i*W +: W];
          valid[i]        <= 1'b1;
          count[i*CW +: CW] <= count[i*CW +: CW] + CW'(1);
          if (valid[i] && !ack[i])
            overrun[i] <= 1'b1;
        end else if (ack[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_strobe_capture_bank.sv
// Self-checking bench for strobe_capture_bank: rising-edge instance plus a both-edges instance for counter wrap.
module tb_strobe_capture_bank;

`ifdef STROBE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  strobe = '0, ack = '0, valid, overrun;
  logic [31:0] data = '0, q;
  logic [15:0] count;
  logic [3:0]  strobe2 = '0, ack2 = '0, valid2, overrun2;
  logic [31:0] data2 = '0, q2;
  logic [15:0] count2;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  strobe_capture_bank #(.NCH(4), .W(8), .CW(4), .EDGE(0)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .data(data), .ack(ack),
    .q(q), .valid(valid), .overrun(overrun), .count(count));

  strobe_capture_bank #(.NCH(4), .W(8), .CW(4), .EDGE(2)) dut2 (
    .clk(clk), .rst(rst), .strobe(strobe2), .data(data2), .ack(ack2),
    .q(q2), .valid(valid2), .overrun(overrun2), .count(count2));

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain_last();
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    exp = exp_q.pop_front();
  endtask

  task automatic test_reset();
    strobe = 4'b1111;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL reset_q actual=%h expected=%h", q, 32'h0); end
    checks++; if (valid !== 4'h0) begin failures++; $display("FAIL reset_valid actual=%b expected=%b", valid, 4'h0); end
    checks++; if (overrun !== 4'h0) begin failures++; $display("FAIL reset_overrun actual=%b expected=%b", overrun, 4'h0); end
    checks++; if (count !== 16'h0) begin failures++; $display("FAIL reset_count actual=%h expected=%h", count, 16'h0); end
    rst = 1'b0;
    for (int c = 0; c < 5 + LAT; c++) begin
      tick();
      checks++; if (valid !== 4'h0) begin failures++; $display("FAIL hold_high_valid cycle=%0d actual=%b expected=%b", c, valid, 4'h0); end
      checks++; if (count !== 16'h0) begin failures++; $display("FAIL hold_high_count cycle=%0d actual=%h expected=%h", c, count, 16'h0); end
    end
    strobe = 4'b0000;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_single_capture();
    data = 32'h0;
    data[23:16] = 8'hA5;
    strobe[2] = 1'b1;
    exp_q.push_back(32'h0000_00A5);
    tick();
    data = 32'h0;
    repeat (LAT - 1) tick();
    exp = exp_q.pop_front();
    checks++; if (q[23:16] !== exp[7:0]) begin failures++; $display("FAIL ch2_q actual=%h expected=%h", q[23:16], exp[7:0]); end
    checks++; if (valid !== 4'b0100) begin failures++; $display("FAIL ch2_valid actual=%b expected=%b", valid, 4'b0100); end
    checks++; if (count[11:8] !== 4'd1) begin failures++; $display("FAIL ch2_count actual=%0d expected=%0d", count[11:8], 1); end
    checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL ch2_overrun actual=%b expected=%b", overrun, 4'b0000); end
    ack[2] = 1'b1;
    tick();
    ack = 4'b0000;
    checks++; if (valid !== 4'b0000) begin failures++; $display("FAIL ch2_ack_valid actual=%b expected=%b", valid, 4'b0000); end
    strobe[2] = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_overrun();
    do_reset();
    data[7:0] = 8'h11;
    strobe[0] = 1'b1;
    exp_q.push_back(32'h11);
    tick();
    strobe[0] = 1'b0;
    tick();
    tick();
    data[7:0] = 8'h22;
    strobe[0] = 1'b1;
    exp_q.push_back(32'h22);
    tick();
    repeat (LAT - 1) tick();
    drain_last();
    checks++; if (q[7:0] !== exp[7:0]) begin failures++; $display("FAIL ovr_q actual=%h expected=%h", q[7:0], exp[7:0]); end
    checks++; if (overrun !== 4'b0001) begin failures++; $display("FAIL ovr_flag actual=%b expected=%b", overrun, 4'b0001); end
    checks++; if (count[3:0] !== 4'd2) begin failures++; $display("FAIL ovr_count actual=%0d expected=%0d", count[3:0], 2); end
    checks++; if (valid !== 4'b0001) begin failures++; $display("FAIL ovr_valid actual=%b expected=%b", valid, 4'b0001); end

    strobe[0] = 1'b0;
    do_reset();
    data[7:0] = 8'h11;
    strobe[0] = 1'b1;
    exp_q.push_back(32'h11);
    tick();
    strobe[0] = 1'b0;
    tick();
    tick();
    data[7:0] = 8'h22;
    strobe[0] = 1'b1;
    exp_q.push_back(32'h22);
    repeat (LAT - 1) tick();
    ack[0] = 1'b1;
    tick();
    ack = 4'b0000;
    drain_last();
    checks++; if (q[7:0] !== exp[7:0]) begin failures++; $display("FAIL ackhit_q actual=%h expected=%h", q[7:0], exp[7:0]); end
    checks++; if (overrun !== 4'b0000) begin failures++; $display("FAIL ackhit_overrun actual=%b expected=%b", overrun, 4'b0000); end
    checks++; if (valid[0] !== 1'b1) begin failures++; $display("FAIL ackhit_valid actual=%b expected=%b", valid[0], 1'b1); end
    checks++; if (count[3:0] !== 4'd2) begin failures++; $display("FAIL ackhit_count actual=%0d expected=%0d", count[3:0], 2); end
    strobe[0] = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      data2[15:8] = 8'(8'h30 + i);
      strobe2[1] = ~strobe2[1];
      exp_q.push_back({24'h0, 8'(8'h30 + i)});
      tick();
      tick();
    end
    repeat (LAT) tick();
    drain_last();
    checks++; if (count2 !== 16'h0000) begin failures++; $display("FAIL wrap_count actual=%h expected=%h", count2, 16'h0000); end
    checks++; if (valid2 !== 4'b0010) begin failures++; $display("FAIL wrap_valid actual=%b expected=%b", valid2, 4'b0010); end
    checks++; if (q2[15:8] !== exp[7:0]) begin failures++; $display("FAIL wrap_q actual=%h expected=%h", q2[15:8], exp[7:0]); end
    checks++; if (overrun2 !== 4'b0010) begin failures++; $display("FAIL wrap_overrun actual=%b expected=%b", overrun2, 4'b0010); end
  endtask

  task automatic test_all_channels();
    do_reset();
    data = 32'hDEADBEEF;
    strobe = 4'b1111;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    repeat (LAT - 1) tick();
    exp = exp_q.pop_front();
    checks++; if (q !== exp) begin failures++; $display("FAIL all_q actual=%h expected=%h", q, exp); end
    checks++; if (valid !== 4'b1111) begin failures++; $display("FAIL all_valid actual=%b expected=%b", valid, 4'b1111); end
    checks++; if (count !== 16'h1111) begin failures++; $display("FAIL all_count actual=%h expected=%h", count, 16'h1111); end
    rst = 1'b1;
    tick();
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL midrst_q actual=%h expected=%h", q, 32'h0); end
    checks++; if (valid !== 4'h0) begin failures++; $display("FAIL midrst_valid actual=%b expected=%b", valid, 4'h0); end
    checks++; if (overrun !== 4'h0) begin failures++; $display("FAIL midrst_overrun actual=%b expected=%b", overrun, 4'h0); end
    checks++; if (count !== 16'h0) begin failures++; $display("FAIL midrst_count actual=%h expected=%h", count, 16'h0); end
    rst = 1'b0;
    repeat (LAT + 2) tick();
    checks++; if (valid !== 4'h0) begin failures++; $display("FAIL postrst_valid actual=%b expected=%b", valid, 4'h0); end
    strobe = 4'b0000;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_latency();
    do_reset();
    data = 32'h0;
    data[31:24] = 8'h3C;
    strobe[3] = 1'b1;
    exp_q.push_back(32'h3C);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      data = 32'h0;
      checks++;
      if (valid[3] !== (c == LAT)) begin
        failures++;
        $display("FAIL latency_valid cycle=%0d actual=%b expected=%b", c, valid[3], (c == LAT));
      end
    end
    exp = exp_q.pop_front();
    checks++; if (q[31:24] !== exp[7:0]) begin failures++; $display("FAIL latency_q actual=%h expected=%h", q[31:24], exp[7:0]); end
    tick();
    checks++; if (count[15:12] !== 4'd1) begin failures++; $display("FAIL latency_count actual=%0d expected=%0d", count[15:12], 1); end
    strobe[3] = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single_capture();
    test_overrun();
    test_wrap();
    test_all_channels();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
